// File: rtl/parking_exit_controller.sv
// Parking-lot exit barrier controller.
// A Moore FSM that asks the driver for an exit code, raises the barrier,
// detects tailgating, and keeps a saturating count of cars inside.
// Optional feature macro: EXIT_TIMEOUT_EN closes the gate if nobody leaves
// within OPEN_CYCLES cycles.
module parking_exit_controller #(
  parameter int unsigned CAPACITY    = 15,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned OPEN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_exit_in,
  input  logic       sensor_exit_out,
  input  logic       entry_pulse,
  input  logic [1:0] code_1,
  input  logic [1:0] code_2,
  output logic       GATE_OPEN,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2,
  output logic [3:0] occupancy,
  output logic       FULL
);

  localparam int unsigned DwellW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitCode  = 3'd1,
    StWrongCode = 3'd2,
    StOpen      = 3'd3,
    StTailgate  = 3'd4
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [DwellW-1:0] r_dwell;
  logic [DwellW-1:0] w_dwell_d;
  logic              r_blink;
  logic              w_blink_d;
  logic [3:0]        r_occ;
  logic [3:0]        w_occ_d;
  logic              w_code_ok;
  logic              w_dwell_done;
  logic              w_full;
  logic              w_dec;
  logic              w_inc;
  logic              w_open_done;

  assign w_code_ok    = (code_1 == 2'b10) && (code_2 == 2'b01);
  assign w_dwell_done = (r_dwell == DwellW'(WAIT_CYCLES - 1));
  assign w_full       = (r_occ == 4'(CAPACITY));

`ifdef EXIT_TIMEOUT_EN
  localparam int unsigned OpenW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  logic [OpenW-1:0] r_open_cnt;
  logic [OpenW-1:0] w_open_cnt_d;

  assign w_open_done  = (r_open_cnt == OpenW'(OPEN_CYCLES - 1));
  assign w_open_cnt_d = (r_state == StOpen && w_state_d == StOpen) ? r_open_cnt + 1'b1 : '0;

  // Gate-open timeout counter, cleared whenever the gate is not open.
  always_ff @(posedge clk) begin
    if (reset) r_open_cnt <= '0;
    else       r_open_cnt <= w_open_cnt_d;
  end
`else
  logic w_unused_open_cycles;
  assign w_unused_open_cycles = (OPEN_CYCLES == 0);
  assign w_open_done          = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (sensor_exit_in && (r_occ != 4'd0)) w_state_d = StWaitCode;
      end
      StWaitCode: begin
        // Car leaving the sensor aborts code entry before the code is judged.
        if (!sensor_exit_in)   w_state_d = StIdle;
        else if (w_dwell_done) w_state_d = w_code_ok ? StOpen : StWrongCode;
      end
      StWrongCode: begin
        if (w_code_ok)           w_state_d = StOpen;
        else if (!sensor_exit_in) w_state_d = StIdle;
      end
      StOpen: begin
        if (sensor_exit_out) w_state_d = sensor_exit_in ? StTailgate : StIdle;
        else if (w_open_done) w_state_d = StIdle;
      end
      StTailgate: begin
        if (w_code_ok) w_state_d = StOpen;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Dwell counter runs only while staying in code entry; blink starts high on entry.
  always_comb begin
    w_dwell_d = (r_state == StWaitCode && w_state_d == StWaitCode) ? r_dwell + 1'b1 : '0;
    w_blink_d = 1'b0;
    if (w_state_d == StWrongCode || w_state_d == StTailgate) begin
      w_blink_d = (w_state_d == r_state) ? ~r_blink : 1'b1;
    end
  end

  // Occupancy update; a departing car frees its slot for a coincident arrival.
  always_comb begin
    w_dec   = (r_state == StOpen) && sensor_exit_out && (r_occ != 4'd0);
    w_inc   = entry_pulse && (!w_full || w_dec);
    w_occ_d = r_occ;
    case ({w_inc, w_dec})
      2'b10:   w_occ_d = r_occ + 4'd1;
      2'b01:   w_occ_d = r_occ - 4'd1;
      default: w_occ_d = r_occ;
    endcase
  end

  // State, counter and lamp registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_dwell <= '0;
      r_blink <= 1'b0;
      r_occ   <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_dwell <= w_dwell_d;
      r_blink <= w_blink_d;
      r_occ   <= w_occ_d;
    end
  end

  // Moore output decode from registered state.
  always_comb begin
    GATE_OPEN = 1'b0;
    GREEN_LED = 1'b0;
    RED_LED   = 1'b0;
    HEX_1     = 7'h7F;
    HEX_2     = 7'h7F;
    unique case (r_state)
      StWaitCode: begin
        RED_LED = 1'b1;
        HEX_1   = 7'b0000110;
        HEX_2   = 7'b0101011;
      end
      StWrongCode: begin
        RED_LED = r_blink;
        HEX_1   = 7'b0000110;
        HEX_2   = 7'b0000110;
      end
      StOpen: begin
        GATE_OPEN = 1'b1;
        GREEN_LED = 1'b1;
        HEX_1     = 7'b0000010;
        HEX_2     = 7'b1000000;
      end
      StTailgate: begin
        RED_LED = r_blink;
        HEX_1   = 7'b0010010;
        HEX_2   = 7'b0001100;
      end
      default: begin
        GATE_OPEN = 1'b0;
      end
    endcase
  end

  assign occupancy = r_occ;
  assign FULL      = w_full;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed testbench for parking_exit_controller (default parameters).
module tb_parking_exit_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_exit_in;
  logic       sensor_exit_out;
  logic       entry_pulse;
  logic [1:0] code_1;
  logic [1:0] code_2;
  logic       GATE_OPEN;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;
  logic [3:0] occupancy;
  logic       FULL;

  int n_tests = 0;
  int n_fail  = 0;

  // {GATE_OPEN, GREEN_LED, RED_LED, HEX_1, HEX_2}
  logic [18:0] obs;
  assign obs = {GATE_OPEN, GREEN_LED, RED_LED, HEX_1, HEX_2};

  localparam logic [18:0] ExpIdle  = {3'b000, 7'h7F, 7'h7F};
  localparam logic [18:0] ExpWait  = {3'b001, 7'b0000110, 7'b0101011};
  localparam logic [18:0] ExpWrong1 = {3'b001, 7'b0000110, 7'b0000110};
  localparam logic [18:0] ExpWrong0 = {3'b000, 7'b0000110, 7'b0000110};
  localparam logic [18:0] ExpOpen  = {3'b110, 7'b0000010, 7'b1000000};
  localparam logic [18:0] ExpTail1 = {3'b001, 7'b0010010, 7'b0001100};
  localparam logic [18:0] ExpTail0 = {3'b000, 7'b0010010, 7'b0001100};

  always #5 clk = ~clk;

  parking_exit_controller dut (
    .clk            (clk),
    .reset          (reset),
    .sensor_exit_in (sensor_exit_in),
    .sensor_exit_out(sensor_exit_out),
    .entry_pulse    (entry_pulse),
    .code_1         (code_1),
    .code_2         (code_2),
    .GATE_OPEN      (GATE_OPEN),
    .GREEN_LED      (GREEN_LED),
    .RED_LED        (RED_LED),
    .HEX_1          (HEX_1),
    .HEX_2          (HEX_2),
    .occupancy      (occupancy),
    .FULL           (FULL)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input logic ok);
    code_1 = ok ? 2'b10 : 2'b00;
    code_2 = ok ? 2'b01 : 2'b00;
  endtask

  task automatic pulses(input int n);
    entry_pulse = 1'b1;
    repeat (n) step();
    entry_pulse = 1'b0;
  endtask

  // Car at exit with correct code: 4 dwell cycles then OPEN.
  task automatic go_open();
    sensor_exit_in = 1'b1;
    set_code(1'b1);
    repeat (5) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    entry_pulse = 1'b1;
    step();
    step();
    entry_pulse = 1'b0;
    reset = 1'b0;
    n_tests++;
    if (obs !== ExpIdle) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, ExpIdle);
    end
    n_tests++;
    if ({FULL, occupancy} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL reset_occupancy: got full=%b occ=%0d expected full=0 occ=0", FULL, occupancy);
    end
  endtask

  task automatic test_exit_flow();
    pulses(3);
    n_tests++;
    if (occupancy !== 4'd3) begin
      n_fail++;
      $display("FAIL entry_count: got %0d expected 3", occupancy);
    end
    sensor_exit_in = 1'b1;
    set_code(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (obs !== ExpWait) begin
        n_fail++;
        $display("FAIL wait_code_cycle%0d: got %h expected %h", i, obs, ExpWait);
      end
    end
    step();
    n_tests++;
    if (obs !== ExpOpen) begin
      n_fail++;
      $display("FAIL open_after_dwell: got %h expected %h", obs, ExpOpen);
    end
    sensor_exit_in = 1'b0;
    sensor_exit_out = 1'b1;
    step();
    sensor_exit_out = 1'b0;
    n_tests++;
    if ({obs, occupancy} !== {ExpIdle, 4'd2}) begin
      n_fail++;
      $display("FAIL exit_decrement: got %h occ=%0d expected %h occ=2", obs, occupancy, ExpIdle);
    end
  endtask

  task automatic test_wrong_code();
    sensor_exit_in = 1'b1;
    set_code(1'b0);
    repeat (5) step();
    n_tests++;
    if (obs !== ExpWrong1) begin
      n_fail++;
      $display("FAIL wrong_entry: got %h expected %h", obs, ExpWrong1);
    end
    step();
    n_tests++;
    if (obs !== ExpWrong0) begin
      n_fail++;
      $display("FAIL wrong_blink0: got %h expected %h", obs, ExpWrong0);
    end
    step();
    n_tests++;
    if (obs !== ExpWrong1) begin
      n_fail++;
      $display("FAIL wrong_blink1: got %h expected %h", obs, ExpWrong1);
    end
    set_code(1'b1);
    step();
    n_tests++;
    if (obs !== ExpOpen) begin
      n_fail++;
      $display("FAIL wrong_to_open: got %h expected %h", obs, ExpOpen);
    end
    sensor_exit_in = 1'b0;
    sensor_exit_out = 1'b1;
    step();
    sensor_exit_out = 1'b0;
    n_tests++;
    if (occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL wrong_exit_occ: got %0d expected 1", occupancy);
    end
  endtask

  task automatic test_tailgate();
    go_open();
    sensor_exit_out = 1'b1;
    step();
    sensor_exit_out = 1'b0;
    set_code(1'b0);
    n_tests++;
    if ({obs, occupancy} !== {ExpTail1, 4'd0}) begin
      n_fail++;
      $display("FAIL tailgate_entry: got %h occ=%0d expected %h occ=0", obs, occupancy, ExpTail1);
    end
    step();
    n_tests++;
    if (obs !== ExpTail0) begin
      n_fail++;
      $display("FAIL tailgate_blink: got %h expected %h", obs, ExpTail0);
    end
    set_code(1'b1);
    step();
    n_tests++;
    if ({obs, occupancy} !== {ExpOpen, 4'd0}) begin
      n_fail++;
      $display("FAIL tailgate_to_open: got %h occ=%0d expected %h occ=0", obs, occupancy, ExpOpen);
    end
    // Exit at zero occupancy must not wrap.
    sensor_exit_in = 1'b0;
    sensor_exit_out = 1'b1;
    step();
    sensor_exit_out = 1'b0;
    n_tests++;
    if ({obs, occupancy} !== {ExpIdle, 4'd0}) begin
      n_fail++;
      $display("FAIL dec_at_zero: got %h occ=%0d expected %h occ=0", obs, occupancy, ExpIdle);
    end
  endtask

  task automatic test_idle_empty();
    sensor_exit_in = 1'b1;
    set_code(1'b1);
    step();
    step();
    n_tests++;
    if (obs !== ExpIdle) begin
      n_fail++;
      $display("FAIL idle_empty: got %h expected %h", obs, ExpIdle);
    end
    sensor_exit_in = 1'b0;
  endtask

  task automatic test_saturation();
    pulses(16);
    n_tests++;
    if ({FULL, occupancy} !== {1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL saturate: got full=%b occ=%0d expected full=1 occ=15", FULL, occupancy);
    end
    go_open();
    sensor_exit_in = 1'b0;
    sensor_exit_out = 1'b1;
    entry_pulse = 1'b1;
    step();
    sensor_exit_out = 1'b0;
    entry_pulse = 1'b0;
    n_tests++;
    if ({FULL, occupancy} !== {1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL simul_inc_dec: got full=%b occ=%0d expected full=1 occ=15", FULL, occupancy);
    end
    go_open();
    sensor_exit_in = 1'b0;
    sensor_exit_out = 1'b1;
    step();
    sensor_exit_out = 1'b0;
    n_tests++;
    if ({FULL, occupancy} !== {1'b0, 4'd14}) begin
      n_fail++;
      $display("FAIL lone_exit_full: got full=%b occ=%0d expected full=0 occ=14", FULL, occupancy);
    end
  endtask

  task automatic test_open_hold();
    go_open();
    sensor_exit_in = 1'b0;
`ifdef EXIT_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
      n_tests++;
      if (GATE_OPEN !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_hold%0d: got %b expected 1", i, GATE_OPEN);
      end
    end
    step();
    n_tests++;
    if ({obs, occupancy} !== {ExpIdle, 4'd14}) begin
      n_fail++;
      $display("FAIL timeout_close: got %h occ=%0d expected %h occ=14", obs, occupancy, ExpIdle);
    end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      n_tests++;
      if (obs !== ExpOpen) begin
        n_fail++;
        $display("FAIL open_persist%0d: got %h expected %h", i, obs, ExpOpen);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulses(5);
    go_open();
    n_tests++;
    if ({obs, occupancy} !== {ExpOpen, 4'd5}) begin
      n_fail++;
      $display("FAIL pre_reset_open: got %h occ=%0d expected %h occ=5", obs, occupancy, ExpOpen);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if ({obs, FULL, occupancy} !== {ExpIdle, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: got %h full=%b occ=%0d expected %h full=0 occ=0",
               obs, FULL, occupancy, ExpIdle);
    end
    reset = 1'b0;
    sensor_exit_in = 1'b0;
    set_code(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    sensor_exit_in = 1'b0;
    sensor_exit_out = 1'b0;
    entry_pulse = 1'b0;
    code_1 = 2'b00;
    code_2 = 2'b00;
    test_reset();
    test_exit_flow();
    test_wrong_code();
    test_tailgate();
    test_idle_empty();
    test_saturation();
    test_open_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
